// File: rtl/mixer_pkg.sv
// Shared definitions for the voice mixer: the FSM state type and the default
// timing and gain constants used by voice_mixer and its gain stage.
package mixer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_WAIT,
        ST_SCALE,
        ST_OUTPUT
    } mix_state_e;

    localparam int         DEFAULT_SAMPLE_DIV    = 1134;   // 50 MHz / 44.1 kHz
    localparam int         DEFAULT_VOICE_TIMEOUT = 15;
    localparam logic [7:0] UNITY_GAIN            = 8'd128; // gain is Q1.7

endpackage

// File: rtl/mixer_scale_sat.sv
// Combinational gain stage: multiplies the signed voice sum by an unsigned
// Q1.7 volume, arithmetic-shifts right by 7 and clamps to signed 16 bits.
//   i_acc     signed voice accumulator (ACC_W bits)
//   i_volume  unsigned gain, 128 = unity
//   o_result  saturated signed 16-bit sample
module mixer_scale_sat #(
    parameter int ACC_W = 19
) (
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic        [7:0]       i_volume,
    output logic signed [15:0]      o_result
);

    // |acc| <= 2^(ACC_W-1), volume < 2^8: product always fits in ACC_W+9 bits
    localparam int PROD_W = ACC_W + 9;
    localparam logic signed [PROD_W-1:0] MAX_V = PROD_W'(32767);
    localparam logic signed [PROD_W-1:0] MIN_V = -PROD_W'(32768);

    logic signed [PROD_W-1:0] w_acc_ext;
    logic signed [PROD_W-1:0] w_vol_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_shift;

    always_comb begin
        w_acc_ext = {{9{i_acc[ACC_W-1]}}, i_acc};
        w_vol_ext = {{(PROD_W-8){1'b0}}, i_volume};
        w_prod    = w_acc_ext * w_vol_ext;
        w_shift   = w_prod >>> 7;
        if (w_shift > MAX_V)
            o_result = 16'sh7FFF;
        else if (w_shift < MIN_V)
            o_result = -16'sh8000;
        else
            o_result = w_shift[15:0];
    end

endmodule

// File: rtl/voice_mixer.sv
// Sample-rate voice mixer. Every SAMPLE_DIV clocks it polls each active voice
// slot for one sample, sums the responses, applies master volume with
// saturation and presents the result to the DAC with a one-cycle strobe.
//   clk, reset      system clock, synchronous active-high reset
//   voice_active    per-slot enable, sampled when the slot is visited
//   voice_req/index request handshake towards the voice engines
//   voice_sample    signed response, qualified by voice_valid
//   master_volume   unsigned gain, 128 = unity, sampled in SCALE
//   mixer_output    held mixed sample; sample_strobe marks each update
//   overrun         sticky: a sample tick landed while a mix was running
module voice_mixer
    import mixer_pkg::*;
#(
    parameter int  NUM_VOICES    = 8,
    parameter int  SAMPLE_DIV    = DEFAULT_SAMPLE_DIV,
    parameter int  VOICE_TIMEOUT = DEFAULT_VOICE_TIMEOUT,
    parameter bit  LATENCY_CHECK = 1'b1,
    localparam int IDX_W         = $clog2(NUM_VOICES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_VOICES-1:0]   voice_active,
    output logic                    voice_req,
    output logic [IDX_W-1:0]        voice_index,
    input  logic signed [15:0]      voice_sample,
    input  logic                    voice_valid,
    input  logic [7:0]              master_volume,
    output logic signed [15:0]      mixer_output,
    output logic                    sample_strobe,
    output logic                    overrun
);

    localparam int ACC_W = 16 + IDX_W;
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int TMO_W = $clog2(VOICE_TIMEOUT + 1);

    if ((1 << IDX_W) != NUM_VOICES || NUM_VOICES < 2 || NUM_VOICES > 16) begin : g_nv_chk
        $error("voice_mixer: NUM_VOICES must be a power of two in 2..16");
    end
    // Latency check can be disabled to build a deliberately overrunning instance
    if (LATENCY_CHECK && (3 + NUM_VOICES * (VOICE_TIMEOUT + 2) >= SAMPLE_DIV)) begin : g_lat_chk
        $error("voice_mixer: worst-case mix latency does not fit in SAMPLE_DIV");
    end

    mix_state_e                r_state;
    logic [DIV_W-1:0]          r_div;
    logic signed [ACC_W-1:0]   r_acc;
    logic [IDX_W-1:0]          r_idx;
    logic [TMO_W-1:0]          r_tmo;
    logic                      r_req;
    logic signed [15:0]        r_result;
    logic signed [15:0]        r_out;
    logic                      r_strobe;
    logic                      r_ovr;

    logic                      w_tick;
    logic                      w_tmo_done;
    logic                      w_advance;
    logic signed [15:0]        w_scaled;

    mixer_scale_sat #(.ACC_W(ACC_W)) u_scale (
        .i_acc    (r_acc),
        .i_volume (master_volume),
        .o_result (w_scaled)
    );

    always_comb begin
        w_tick     = (r_div == DIV_W'(SAMPLE_DIV - 1));
        w_tmo_done = (r_tmo == TMO_W'(VOICE_TIMEOUT - 1));
        w_advance  = 1'b0;
        case (r_state)
            ST_REQUEST: w_advance = !voice_active[r_idx];   // skip inactive slot
            ST_WAIT:    w_advance = voice_valid || w_tmo_done;
            default:    w_advance = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_div    <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_tmo    <= '0;
            r_req    <= 1'b0;
            r_result <= '0;
            r_out    <= '0;
            r_strobe <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_div    <= w_tick ? '0 : r_div + 1'b1;
            r_strobe <= 1'b0;
            // A tick outside IDLE is dropped; the running mix is left alone
            if (w_tick && r_state != ST_IDLE)
                r_ovr <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (voice_active[r_idx]) begin
                        r_req   <= 1'b1;
                        r_tmo   <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (voice_valid)
                        r_acc <= r_acc + {{IDX_W{voice_sample[15]}}, voice_sample};
                    if (voice_valid || w_tmo_done)
                        r_req <= 1'b0;      // a timed-out voice contributes nothing
                    else
                        r_tmo <= r_tmo + 1'b1;
                end
                ST_SCALE: begin
                    r_result <= w_scaled;
                    r_state  <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    r_out    <= r_result;
                    r_strobe <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_advance) begin
                if (r_idx == IDX_W'(NUM_VOICES - 1)) begin
                    r_state <= ST_SCALE;
                end else begin
                    r_idx   <= r_idx + 1'b1;
                    r_state <= ST_REQUEST;
                end
            end
        end
    end

    assign voice_req     = r_req;
    assign voice_index   = r_idx;
    assign mixer_output  = r_out;
    assign sample_strobe = r_strobe;
    assign overrun       = r_ovr;

endmodule
